// File: rtl/memory_arbiter_np.sv
// Single-outstanding memory arbiter: NUM_PORTS requesters share one downstream port.
// Define MEMORY_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (highest index wins).
module memory_arbiter_np #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic [NUM_PORTS-1:0]                  port_valid_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wr_data_i,
  input  logic [NUM_PORTS-1:0]                  port_write_i,
  output logic [NUM_PORTS-1:0]                  port_ready_o,
  output logic [NUM_PORTS-1:0]                  port_resp_valid_o,
  output logic [DATA_WIDTH-1:0]                 port_rd_data_o,
  output logic                                  mem_valid_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic [DATA_WIDTH-1:0]                 mem_wr_data_o,
  output logic                                  mem_write_o,
  input  logic                                  mem_ready_i,
  input  logic                                  mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]                 mem_rd_data_i,
  output logic [NUM_PORTS-1:0]                  grant_o,
  output logic                                  busy_o
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant;
  logic [NUM_PORTS-1:0] w_grant_nxt;
  logic [IDX_W-1:0]     w_gidx;
  logic [NUM_PORTS-1:0] w_win;
  logic                 w_any;
  logic                 w_gvalid;

  // Encode the one-hot registered grant into an index
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[IDX_W'(i)]) w_gidx = IDX_W'(i);
    end
  end

  assign w_gvalid = port_valid_i[w_gidx];
  assign w_any    = |port_valid_i;

`ifdef MEMORY_ARBITER_RR_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;

  // First requester at or after the pointer, wrapping modulo NUM_PORTS
  always_comb begin
    logic             found;
    int unsigned      j;
    w_win = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = 32'(r_ptr) + 32'(k);
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!found && port_valid_i[IDX_W'(j)]) begin
        w_win[IDX_W'(j)] = 1'b1;
        found            = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the last (highest) set index overrides lower ones
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_valid_i[IDX_W'(i)]) begin
        w_win                = '0;
        w_win[IDX_W'(i)]     = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_grant <= '0;
`ifdef MEMORY_ARBITER_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
`ifdef MEMORY_ARBITER_RR_EN
      r_ptr   <= w_ptr_nxt;
`endif
    end
  end

  // Next state plus request/response steering to the granted port
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
`ifdef MEMORY_ARBITER_RR_EN
    w_ptr_nxt         = r_ptr;
`endif
    port_ready_o      = '0;
    port_resp_valid_o = '0;
    mem_valid_o       = 1'b0;
    mem_addr_o        = '0;
    mem_wr_data_o     = '0;
    mem_write_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_win;
          w_state_nxt = S_REQUEST;
        end
      end
      S_REQUEST: begin
        mem_valid_o           = w_gvalid;
        mem_addr_o            = port_addr_i[w_gidx];
        mem_wr_data_o         = port_wr_data_i[w_gidx];
        mem_write_o           = port_write_i[w_gidx];
        port_ready_o[w_gidx]  = mem_ready_i & w_gvalid;
        if (!w_gvalid) begin
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (mem_ready_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        port_resp_valid_o[w_gidx] = mem_resp_valid_i;
        if (mem_resp_valid_i) begin
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
`ifdef MEMORY_ARBITER_RR_EN
          w_ptr_nxt   = (w_gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_gidx + IDX_W'(1);
`endif
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign port_rd_data_o = mem_rd_data_i;
  assign grant_o        = r_grant;
  assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_memory_arbiter_np.sv
// Directed bench for memory_arbiter_np with NUM_PORTS=3; arbitration tests follow MEMORY_ARBITER_RR_EN.
module tb_memory_arbiter_np;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic                   clk_i = 1'b0;
  logic                   reset_ni;
  logic [NP-1:0]          port_valid_i;
  logic [NP-1:0][AW-1:0]  port_addr_i;
  logic [NP-1:0][DW-1:0]  port_wr_data_i;
  logic [NP-1:0]          port_write_i;
  logic [NP-1:0]          port_ready_o;
  logic [NP-1:0]          port_resp_valid_o;
  logic [DW-1:0]          port_rd_data_o;
  logic                   mem_valid_o;
  logic [AW-1:0]          mem_addr_o;
  logic [DW-1:0]          mem_wr_data_o;
  logic                   mem_write_o;
  logic                   mem_ready_i;
  logic                   mem_resp_valid_i;
  logic [DW-1:0]          mem_rd_data_i;
  logic [NP-1:0]          grant_o;
  logic                   busy_o;

  int n_checks = 0;
  int n_errors = 0;

  memory_arbiter_np #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .port_valid_i(port_valid_i), .port_addr_i(port_addr_i),
    .port_wr_data_i(port_wr_data_i), .port_write_i(port_write_i),
    .port_ready_o(port_ready_o), .port_resp_valid_o(port_resp_valid_o),
    .port_rd_data_o(port_rd_data_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_write_o(mem_write_o),
    .mem_ready_i(mem_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_rd_data_i(mem_rd_data_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs checked after #1
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Drive one full handshake + response for the port currently granted in REQUEST
  task automatic serve(input int unsigned port, input string tag);
    logic [NP-1:0] oh;
    oh = NP'(1) << port;
    #1;
    check({tag, "_grant"}, 64'(grant_o), 64'(oh));
    mem_ready_i = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(port_ready_o), 64'(oh));
    tick();
    mem_ready_i      = 1'b0;
    mem_resp_valid_i = 1'b1;
    #1;
    check({tag, "_resp"}, 64'(port_resp_valid_o), 64'(oh));
    tick();
    mem_resp_valid_i = 1'b0;
    #1;
    check({tag, "_idle"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    reset_ni         = 1'b0;
    port_valid_i     = '0;
    port_addr_i      = '0;
    port_wr_data_i   = '0;
    port_write_i     = '0;
    mem_ready_i      = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_rd_data_i    = 32'h0000_A5A5;
    tick();
    tick();
    #1;
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_mem_valid", 64'(mem_valid_o), 64'(0));
    check("rst_ready", 64'(port_ready_o), 64'(0));
    check("rst_rd_data", 64'(port_rd_data_o), 64'h0000_A5A5);

    // Port 1 read of 0x100, memory accepts after two cycles
    tick();
    reset_ni        = 1'b1;
    port_valid_i    = 3'b010;
    port_addr_i[1]  = 32'h100;
    #1;
    check("rd_idle_mvalid", 64'(mem_valid_o), 64'(0));
    tick();
    #1;
    check("rd_grant", 64'(grant_o), 64'(3'b010));
    check("rd_mvalid", 64'(mem_valid_o), 64'(1));
    check("rd_addr", 64'(mem_addr_o), 64'h100);
    check("rd_write", 64'(mem_write_o), 64'(0));
    check("rd_noready0", 64'(port_ready_o), 64'(0));
    tick();
    #1;
    check("rd_noready1", 64'(port_ready_o), 64'(0));
    tick();
    mem_ready_i = 1'b1;
    #1;
    check("rd_ready", 64'(port_ready_o), 64'(3'b010));
    tick();
    port_valid_i = '0;
    #1;
    check("wait_mvalid", 64'(mem_valid_o), 64'(0));
    check("wait_ready_ignored", 64'(port_ready_o), 64'(0));
    check("wait_busy", 64'(busy_o), 64'(1));
    tick();
    mem_ready_i      = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_rd_data_i    = 32'hDEAD_BEEF;
    #1;
    check("rd_resp", 64'(port_resp_valid_o), 64'(3'b010));
    check("rd_data", 64'(port_rd_data_o), 64'hDEAD_BEEF);
    tick();
    #1;
    check("rd_back_idle", 64'(busy_o), 64'(0));
    check("rd_grant_clr", 64'(grant_o), 64'(0));
    check("idle_resp_ignored", 64'(port_resp_valid_o), 64'(0));
    mem_resp_valid_i = 1'b0;

    // Port 0 write of 0x12345678 to 0x40
    port_valid_i      = 3'b001;
    port_write_i      = 3'b001;
    port_addr_i[0]    = 32'h40;
    port_wr_data_i[0] = 32'h1234_5678;
    tick();
    #1;
    check("wr_write", 64'(mem_write_o), 64'(1));
    check("wr_data", 64'(mem_wr_data_o), 64'h1234_5678);
    check("wr_addr", 64'(mem_addr_o), 64'h40);
    serve(0, "wr");
    port_valid_i = '0;
    port_write_i = '0;

    // Reset while waiting for a response abandons the transaction
    port_valid_i = 3'b010;
    tick();
    mem_ready_i = 1'b1;
    tick();
    port_valid_i = '0;
    mem_ready_i  = 1'b0;
    reset_ni     = 1'b0;
    #1;
    check("rstw_busy_before", 64'(busy_o), 64'(1));
    tick();
    reset_ni         = 1'b1;
    mem_resp_valid_i = 1'b1;
    #1;
    check("rstw_resp", 64'(port_resp_valid_o), 64'(0));
    check("rstw_busy", 64'(busy_o), 64'(0));
    check("rstw_grant", 64'(grant_o), 64'(0));
    check("rstw_mvalid", 64'(mem_valid_o), 64'(0));
    tick();
    mem_resp_valid_i = 1'b0;

    // Port 1 withdraws in REQUEST before the memory accepts
    port_valid_i = 3'b010;
    tick();
    port_valid_i = '0;
    #1;
    check("drop_ready", 64'(port_ready_o), 64'(0));
    check("drop_mvalid", 64'(mem_valid_o), 64'(0));
    tick();
    #1;
    check("drop_busy", 64'(busy_o), 64'(0));
    check("drop_grant", 64'(grant_o), 64'(0));

`ifdef MEMORY_ARBITER_RR_EN
    // Pointer still 0 after the withdrawal: order 0,1,2,0 with an idle cycle between
    port_valid_i = 3'b111;
    tick();
    serve(0, "rr0");
    tick();
    serve(1, "rr1");
    tick();
    serve(2, "rr2");
    tick();
    serve(0, "rr3");
    port_valid_i = '0;
`else
    // Fixed priority: port 2 beats port 0 and keeps winning while it re-requests
    port_valid_i = 3'b101;
    tick();
    serve(2, "fp0");
    tick();
    serve(2, "fp1");
    port_valid_i = 3'b001;
    tick();
    serve(0, "fp2");
    port_valid_i = '0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter_np.md
MEMORY_ARBITER_NP -- requirements
Module: memory_arbiter_np

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting ports (legal 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, read/write data width.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1, reset; one clock, reset synchronous and active-low.
REQ-006 SHALL have port port_valid_i, input, NUM_PORTS, per-port request valid.
REQ-007 SHALL have port port_addr_i, input, NUM_PORTS x ADDR_WIDTH, per-port address.
REQ-008 SHALL have port port_wr_data_i, input, NUM_PORTS x DATA_WIDTH, per-port write data.
REQ-009 SHALL have port port_write_i, input, NUM_PORTS, per-port write (1) / read (0).
REQ-010 SHALL have port port_ready_o, output, NUM_PORTS, per-port request-accepted pulse.
REQ-011 SHALL have port port_resp_valid_o, output, NUM_PORTS, per-port completion pulse.
REQ-012 SHALL have port port_rd_data_o, output, DATA_WIDTH, read data broadcast to all ports.
REQ-013 SHALL have ports mem_valid_o (output, 1), mem_addr_o (output, ADDR_WIDTH), mem_wr_data_o (output, DATA_WIDTH), mem_write_o (output, 1): downstream request.
REQ-014 SHALL have ports mem_ready_i (input, 1, request accepted), mem_resp_valid_i (input, 1, completion), mem_rd_data_i (input, DATA_WIDTH, read data).
REQ-015 SHALL have ports grant_o, output, NUM_PORTS, one-hot registered grant (all-zero in IDLE); busy_o, output, 1, state != IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> REQUEST -> WAIT -> IDLE; exactly one downstream transaction outstanding.
REQ-017 IDLE: if any port_valid_i bit set, SHALL register winner into grant and go to REQUEST next cycle; else stay.
REQ-018 REQUEST: mem_valid_o SHALL equal port_valid_i[g]; mem_addr_o/mem_wr_data_o/mem_write_o SHALL be granted port's inputs (combinational mux on registered grant).
REQ-019 REQUEST: port_ready_o[g] SHALL equal mem_ready_i & port_valid_i[g]; on that handshake go to WAIT.
REQ-020 REQUEST: if port_valid_i[g] drops before handshake, SHALL return to IDLE with no transaction and no pointer update.
REQ-021 WAIT: on mem_resp_valid_i, port_resp_valid_o[g] SHALL be 1 that cycle only, then go to IDLE; write transactions also complete this way.
REQ-022 port_rd_data_o SHALL equal mem_rd_data_i in all states; ports qualify with port_resp_valid_o.
REQ-023 mem_resp_valid_i outside WAIT and mem_ready_i outside REQUEST SHALL be ignored.
REQ-024 Non-granted ports SHALL see port_ready_o and port_resp_valid_o at 0; mem_valid_o SHALL be 0 in IDLE and WAIT.
REQ-025 Minimum latency: request seen in IDLE cycle N -> mem_valid_o cycle N+1; response cycle M -> next arbitration in IDLE cycle M+1; i.e. one idle cycle between transactions.
REQ-026 Requests arriving in REQUEST/WAIT SHALL wait; ports hold valid and payload stable until port_ready_o.
REQ-027 NUM_PORTS=1 SHALL work identically with grant_o constant 1 outside IDLE.

Reset
REQ-028 On clk_i edge with reset_ni=0: state IDLE, grant 0, round-robin pointer 0; all outputs 0 except port_rd_data_o (follows mem_rd_data_i).
REQ-029 Reset mid-transaction SHALL abandon it silently; no port_resp_valid_o issued for it afterwards.

Configuration
REQ-030 Macro MEMORY_ARBITER_RR_EN defined: round-robin; search starts at pointer, pointer becomes g+1 (mod NUM_PORTS) on each completed response.
REQ-031 Macro undefined: fixed priority, highest index wins; no pointer register exists.

Verification
REQ-032 NUM_PORTS=3, only port 1 reads addr 0x100, mem_ready_i after 2 cycles, resp data 0xDEADBEEF -> grant_o=3'b010, one port_ready_o[1], port_resp_valid_o[1]=1 with port_rd_data_o=0xDEADBEEF, back to IDLE.
REQ-033 RR_EN, ports 0,1,2 request continuously from reset -> service order 0,1,2,0; exactly one idle cycle between transactions.
REQ-034 RR_EN undefined, ports 0 and 2 request together -> port 2 served first; port 2 re-requests -> port 2 again, port 0 starved.
REQ-035 Port 0 write addr 0x40 data 0x12345678 -> mem_write_o=1, mem_wr_data_o=0x12345678 during REQUEST; port_resp_valid_o[0] on completion.
REQ-036 Port 1 drops valid in REQUEST before mem_ready_i -> IDLE next cycle, no port_ready_o, pointer unchanged.
REQ-037 reset_ni=0 in WAIT, then mem_resp_valid_i=1 -> outputs 0, no port_resp_valid_o, busy_o=0.
